// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the two-requester shift arbiter and its shift core.
package shift_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  localparam logic SHIFT_OP_SLL = 1'b0;
  localparam logic SHIFT_OP_SRA = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              op;
  } shift_req_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the result consumer.
interface shift_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic [AMT_W-1:0]  req0_amt;
  logic              req0_op;
  logic              req0_ready;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic [AMT_W-1:0]  req1_amt;
  logic              req1_op;
  logic              req1_ready;

  logic              resp_valid;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;
  logic              resp_ready;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_op,
    input  req1_valid, req1_data, req1_amt, req1_op,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data,
    input  resp_ready
  );

  // Requesters + consumer side
  modport master (
    output req0_valid, req0_data, req0_amt, req0_op,
    output req1_valid, req1_data, req1_amt, req1_op,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data,
    output resp_ready
  );
endinterface

// File: rtl/shift_core.sv
// Combinational shift datapath: log-stage left and arithmetic-right barrel shifters plus a 2:1 select.
module shift_core
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic              op_i,
  output logic [DATA_W-1:0] res_o
);

  logic [AMT_W:0][DATA_W-1:0] sll_st;
  logic [AMT_W:0][DATA_W-1:0] sra_st;

  assign sll_st[0] = data_i;
  assign sra_st[0] = data_i;

  // Stage i shifts by 2**i when amt bit i is set; sra refills from the operand sign bit.
  for (genvar i = 0; i < AMT_W; i++) begin : g_stage
    localparam int SH = 1 << i;
    assign sll_st[i+1] = amt_i[i] ? {sll_st[i][DATA_W-1-SH:0], {SH{1'b0}}} : sll_st[i];
    assign sra_st[i+1] = amt_i[i] ? {{SH{data_i[DATA_W-1]}}, sra_st[i][DATA_W-1:SH]} : sra_st[i];
  end

  assign res_o = (op_i == SHIFT_OP_SRA) ? sra_st[AMT_W] : sll_st[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift core between two requesters, with a single registered
// response slot that can drain and refill in the same cycle.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  shift_arbiter_if.slave  bus
);

  state_t            state_q;
  logic              ptr_q;
  logic              resp_valid_q;
  logic              resp_id_q;
  logic [DATA_W-1:0] resp_data_q;

  logic              slot_avail;
  logic              gnt0, gnt1;
  shift_req_t        req0, req1, sel_req_d;
  logic [DATA_W-1:0] shift_res;

  assign req0 = '{data: bus.req0_data, amt: bus.req0_amt, op: bus.req0_op};
  assign req1 = '{data: bus.req1_data, amt: bus.req1_amt, op: bus.req1_op};

  assign slot_avail = (state_q == ST_EMPTY) || bus.resp_ready;

  // Contested grants follow the pointer; no grant is issued during reset.
  assign gnt0 = ~reset & slot_avail & bus.req0_valid & (~bus.req1_valid | ~ptr_q);
  assign gnt1 = ~reset & slot_avail & bus.req1_valid & (~bus.req0_valid |  ptr_q);

  assign sel_req_d = gnt1 ? req1 : req0;

  shift_core u_core (
    .data_i (sel_req_d.data),
    .amt_i  (sel_req_d.amt),
    .op_i   (sel_req_d.op),
    .res_o  (shift_res)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      ptr_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (gnt0 | gnt1) begin
            state_q      <= ST_FULL;
            resp_valid_q <= 1'b1;
            resp_id_q    <= gnt1;
            resp_data_q  <= shift_res;
            ptr_q        <= ~gnt1;
          end
        end
        ST_FULL: begin
          if (gnt0 | gnt1) begin
            state_q      <= ST_FULL;
            resp_valid_q <= 1'b1;
            resp_id_q    <= gnt1;
            resp_data_q  <= shift_res;
            ptr_q        <= ~gnt1;
          end else if (bus.resp_ready) begin
            state_q      <= ST_EMPTY;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_EMPTY;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomised checks of grant order, backpressure, reset and shift results.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  shift_arbiter_if sif ();

  shift_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [31:0] d,
                         input logic [4:0] a, input logic op);
    if (r == 0) begin
      sif.req0_valid = v; sif.req0_data = d; sif.req0_amt = a; sif.req0_op = op;
    end else begin
      sif.req1_valid = v; sif.req1_data = d; sif.req1_amt = a; sif.req1_op = op;
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a, input logic op);
    logic signed [31:0] s;
    s = d;
    return op ? 32'(s >>> a) : (d << a);
  endfunction

  // random-phase state
  logic [31:0] pd [2];
  logic [4:0]  pa [2];
  logic        po [2];
  logic        pv [2];
  logic        exp_valid, exp_id, mptr, avail, e0, e1, r0, r1, g;
  logic [31:0] exp_data;
  int          grants, cycles;

  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, 32'h0, 5'd0, SHIFT_OP_SLL);
    set_req(1, 1'b0, 32'h0, 5'd0, SHIFT_OP_SLL);
    sif.resp_ready = 1'b1;
    step();
    step();

    // reset state, request held off while reset is high
    set_req(0, 1'b1, 32'h0000_0001, 5'd4, SHIFT_OP_SLL);
    #1 chk("rst_rdy0", 32'(sif.req0_ready), 32'h0);
    step();
    chk("rst_valid", 32'(sif.resp_valid), 32'h0);
    chk("rst_id", 32'(sif.resp_id), 32'h0);
    chk("rst_data", sif.resp_data, 32'h0);

    // single sll from requester 0
    reset = 1'b0;
    #1 chk("sll_rdy0", 32'(sif.req0_ready), 32'h1);
    chk("sll_rdy1", 32'(sif.req1_ready), 32'h0);
    step();
    chk("sll_valid", 32'(sif.resp_valid), 32'h1);
    chk("sll_id", 32'(sif.resp_id), 32'h0);
    chk("sll_data", sif.resp_data, 32'h0000_0010);

    // requester 1: sra by 31, then amt 0 passthrough
    set_req(0, 1'b0, 32'h0, 5'd0, SHIFT_OP_SLL);
    set_req(1, 1'b1, 32'h8000_0000, 5'd31, SHIFT_OP_SRA);
    #1 chk("sra_rdy1", 32'(sif.req1_ready), 32'h1);
    step();
    chk("sra_id", 32'(sif.resp_id), 32'h1);
    chk("sra_data", sif.resp_data, 32'hFFFF_FFFF);
    set_req(1, 1'b1, 32'h1234_5678, 5'd0, SHIFT_OP_SRA);
    #1 chk("amt0_rdy1", 32'(sif.req1_ready), 32'h1);
    step();
    chk("amt0_data", sif.resp_data, 32'h1234_5678);
    set_req(1, 1'b0, 32'h0, 5'd0, SHIFT_OP_SLL);
    step();
    chk("drain_valid", 32'(sif.resp_valid), 32'h0);

    // alternation from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 1'b1, 32'h0000_00A5, 5'd1, SHIFT_OP_SLL);
    set_req(1, 1'b1, 32'hF000_0000, 5'd4, SHIFT_OP_SRA);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("alt%0d_rdy0", k), 32'(sif.req0_ready), 32'((k % 2) == 0));
      chk($sformatf("alt%0d_rdy1", k), 32'(sif.req1_ready), 32'((k % 2) == 1));
      step();
      chk($sformatf("alt%0d_valid", k), 32'(sif.resp_valid), 32'h1);
      chk($sformatf("alt%0d_id", k), 32'(sif.resp_id), 32'(k % 2));
      chk($sformatf("alt%0d_data", k), sif.resp_data,
          ((k % 2) == 0) ? 32'h0000_014A : 32'hFF00_0000);
    end

    // backpressure with both valid, then drain + refill
    sif.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_rdy0", k), 32'(sif.req0_ready), 32'h0);
      chk($sformatf("stall%0d_rdy1", k), 32'(sif.req1_ready), 32'h0);
      step();
      chk($sformatf("stall%0d_valid", k), 32'(sif.resp_valid), 32'h1);
      chk($sformatf("stall%0d_id", k), 32'(sif.resp_id), 32'h1);
      chk($sformatf("stall%0d_data", k), sif.resp_data, 32'hFF00_0000);
    end
    sif.resp_ready = 1'b1;
    #1 chk("refill_rdy0", 32'(sif.req0_ready), 32'h1);
    chk("refill_rdy1", 32'(sif.req1_ready), 32'h0);
    step();
    chk("refill_valid", 32'(sif.resp_valid), 32'h1);
    chk("refill_id", 32'(sif.resp_id), 32'h0);
    chk("refill_data", sif.resp_data, 32'h0000_014A);

    // reset while FULL with req0 valid (pointer currently favours 1)
    set_req(1, 1'b0, 32'h0, 5'd0, SHIFT_OP_SLL);
    reset = 1'b1;
    #1 chk("midrst_rdy0", 32'(sif.req0_ready), 32'h0);
    step();
    reset = 1'b0;
    set_req(0, 1'b0, 32'h0, 5'd0, SHIFT_OP_SLL);
    chk("midrst_valid", 32'(sif.resp_valid), 32'h0);
    step();
    chk("midrst_stale", 32'(sif.resp_valid), 32'h0);
    set_req(0, 1'b1, 32'h0000_0003, 5'd2, SHIFT_OP_SLL);
    set_req(1, 1'b1, 32'h0000_0003, 5'd2, SHIFT_OP_SLL);
    #1 chk("midrst_rdy0", 32'(sif.req0_ready), 32'h1);
    chk("midrst_rdy1", 32'(sif.req1_ready), 32'h0);
    step();
    chk("midrst_id", 32'(sif.resp_id), 32'h0);
    chk("midrst_data", sif.resp_data, 32'h0000_000C);

    // random sweep against a behavioural model
    reset = 1'b1;
    set_req(0, 1'b0, 32'h0, 5'd0, SHIFT_OP_SLL);
    set_req(1, 1'b0, 32'h0, 5'd0, SHIFT_OP_SLL);
    step();
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pv[r] = 1'b0; pd[r] = '0; pa[r] = '0; po[r] = 1'b0;
    end
    exp_valid = 1'b0; exp_id = 1'b0; exp_data = '0; mptr = 1'b0;
    grants = 0;
    cycles = 0;
    while (grants < 1000 && cycles < 6000) begin
      cycles++;
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 3) != 0) begin
          pv[r] = 1'b1;
          pd[r] = $urandom;
          pa[r] = 5'($urandom_range(0, 31));
          po[r] = 1'($urandom_range(0, 1));
        end
        set_req(r, pv[r], pd[r], pa[r], po[r]);
      end
      sif.resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      r0 = sif.req0_ready;
      r1 = sif.req1_ready;
      avail = !exp_valid || sif.resp_ready;
      e0 = avail && pv[0] && (!pv[1] || !mptr);
      e1 = avail && pv[1] && (!pv[0] ||  mptr);
      chk("rnd_rdy0", 32'(r0), 32'(e0));
      chk("rnd_rdy1", 32'(r1), 32'(e1));
      chk("rnd_rdy_wo_vld", 32'((r0 && !pv[0]) || (r1 && !pv[1])), 32'h0);
      if (e0 || e1) begin
        g = e1;
        exp_valid = 1'b1;
        exp_id    = g;
        exp_data  = ref_shift(pd[g], pa[g], po[g]);
        mptr      = ~g;
        pv[g]     = 1'b0;
        grants++;
      end else if (exp_valid && sif.resp_ready) begin
        exp_valid = 1'b0;
      end
      step();
      chk("rnd_valid", 32'(sif.resp_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("rnd_id", 32'(sif.resp_id), 32'(exp_id));
        chk("rnd_data", sif.resp_data, exp_data);
      end
    end
    chk("rnd_grant_count", 32'(grants), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
